// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer between execute and a 64 x 32-bit word-addressed data memory.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses raise resp_err instead of being force-aligned.
module load_store_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WORD_IDX_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WORD_IDX_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [WORD_IDX_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic accept;
  logic illegal;
  logic misalign;

  // Load result: pick the lane, then sign- or zero-extend
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Store merge: overlay the store lane onto the word read back from memory
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    case (f3[1:0])
      2'b00: begin
        case (lo)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lo[1]) r[31:16] = wd[15:0];
        else       r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign accept  = req_valid && req_ready_q;
  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_store && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = 32'h0;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = !accept;
        if (accept) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (illegal || misalign) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_store && (req_funct3[1:0] == 2'b10)) begin
            state_d     = ST_WR;
            mem_write_d = 1'b1;
            mem_addr_d  = WORD_IDX_W'(req_addr[ADDR_W-1:2]);
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = ST_RD;
            mem_read_d = 1'b1;
            mem_addr_d = WORD_IDX_W'(req_addr[ADDR_W-1:2]);
          end
        end
      end
      ST_RD: begin
        if (store_q) begin
          state_d     = ST_WR;
          mem_write_d = 1'b1;
          mem_addr_d  = WORD_IDX_W'(addr_q[ADDR_W-1:2]);
          mem_wdata_d = merge(mem_rdata, funct3_q, addr_q[1:0], wdata_q);
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = extract(mem_rdata, funct3_q, addr_q[1:0]);
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = accept || (state_q != ST_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural 64 x 32 data memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;
  int both_hi = 0;
  logic [5:0]  last_wr_idx = '0;
  logic [31:0] last_wr_data = '0;
  logic [5:0]  last_rd_idx = '0;

  load_store_unit #(.ADDR_W(8), .WORD_IDX_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (mem_write) begin
      wr_count     <= wr_count + 1;
      last_wr_idx  <= mem_addr;
      last_wr_data <= mem_wdata;
    end
    if (mem_read) begin
      rd_count    <= rd_count + 1;
      last_rd_idx <= mem_addr;
    end
    if (mem_read && mem_write) both_hi <= both_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request; lat counts cycles from accept to the resp_valid cycle
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int not_ready_viol);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    not_ready_viol = 0;
    while (resp_valid !== 1'b1 && lat < 10) begin
      if (req_ready !== 1'b0) not_ready_viol++;
      @(negedge clk);
      lat++;
    end
    if (req_ready !== 1'b0) not_ready_viol++;
    rd = resp_rdata;
    er = resp_err;
  endtask

  int          lat;
  int          nrv;
  logic [31:0] rd;
  logic        er;
  int          wr0;
  int          rd0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 8'h00; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // SW then LW of word 2
    wr0 = wr_count;
    do_req(1'b1, 3'b010, 8'h08, 32'h0000006E, lat, rd, er, nrv);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_resp_rdata", rd, 32'h0);
    check("sw_resp_err", 32'(er), 32'h0);
    check("sw_write_count", 32'(wr_count - wr0), 32'd1);
    check("sw_write_idx", 32'(last_wr_idx), 32'd2);
    check("sw_write_data", last_wr_data, 32'h0000006E);
    do_req(1'b0, 3'b010, 8'h08, 32'h0, lat, rd, er, nrv);
    check("lw_latency", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'h0000006E);

    // SB read-modify-write into word 14 lane 2
    preload(6'd14, 32'h11223344);
    wr0 = wr_count;
    do_req(1'b1, 3'b000, 8'h3A, 32'h000000AB, lat, rd, er, nrv);
    check("sb_latency", 32'(lat), 32'd3);
    check("sb_read_idx", 32'(last_rd_idx), 32'd14);
    check("sb_write_idx", 32'(last_wr_idx), 32'd14);
    check("sb_write_data", last_wr_data, 32'h11AB3344);
    check("sb_write_count", 32'(wr_count - wr0), 32'd1);
    check("sb_mem_word", mem[14], 32'h11AB3344);
    check("sb_ready_low", 32'(nrv), 32'd0);

    // Load extraction on word 3
    preload(6'd3, 32'h80FF7F01);
    do_req(1'b0, 3'b000, 8'h0C, 32'h0, lat, rd, er, nrv);
    check("lb_0c", rd, 32'h00000001);
    do_req(1'b0, 3'b000, 8'h0E, 32'h0, lat, rd, er, nrv);
    check("lb_0e", rd, 32'hFFFFFFFF);
    do_req(1'b0, 3'b100, 8'h0E, 32'h0, lat, rd, er, nrv);
    check("lbu_0e", rd, 32'h000000FF);
    do_req(1'b0, 3'b001, 8'h0E, 32'h0, lat, rd, er, nrv);
    check("lh_0e", rd, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 8'h0E, 32'h0, lat, rd, er, nrv);
    check("lhu_0e", rd, 32'h000080FF);
    do_req(1'b0, 3'b001, 8'h0C, 32'h0, lat, rd, er, nrv);
    check("lh_0c", rd, 32'h00007F01);

    // Misaligned LW at 0x05
    preload(6'd1, 32'hCAFEF00D);
    rd0 = rd_count;
    do_req(1'b0, 3'b010, 8'h05, 32'h0, lat, rd, er, nrv);
`ifdef MISALIGN_TRAP_EN
    check("mis_lw_err", 32'(er), 32'h1);
    check("mis_lw_latency", 32'(lat), 32'd1);
    check("mis_lw_rdata", rd, 32'h0);
    check("mis_lw_no_read", 32'(rd_count - rd0), 32'd0);
`else
    check("mis_lw_err", 32'(er), 32'h0);
    check("mis_lw_latency", 32'(lat), 32'd2);
    check("mis_lw_rdata", rd, 32'hCAFEF00D);
    check("mis_lw_read_idx", 32'(last_rd_idx), 32'd1);
`endif

    // Illegal funct3 never touches memory
    rd0 = rd_count;
    wr0 = wr_count;
    do_req(1'b0, 3'b011, 8'h10, 32'h0, lat, rd, er, nrv);
    check("ill_err", 32'(er), 32'h1);
    check("ill_latency", 32'(lat), 32'd1);
    check("ill_no_access", 32'((rd_count - rd0) + (wr_count - wr0)), 32'd0);
    do_req(1'b0, 3'b111, 8'h10, 32'h0, lat, rd, er, nrv);
    check("ill_111_err", 32'(er), 32'h1);

    // Top word 63: SH upper half, then LHU back
    preload(6'd63, 32'hAAAABBBB);
    do_req(1'b1, 3'b001, 8'hFE, 32'h00001234, lat, rd, er, nrv);
    check("sh_top_latency", 32'(lat), 32'd3);
    check("sh_top_word", mem[63], 32'h1234BBBB);
    do_req(1'b0, 3'b101, 8'hFE, 32'h0, lat, rd, er, nrv);
    check("lhu_top", rd, 32'h00001234);

    // Reset during the RD cycle of an SH
    preload(6'd5, 32'h12345678);
    wr0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_addr = 8'h16;
    req_wdata = 32'h0000BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_rd_mem_read", 32'(mem_read), 32'h1);
    check("rst_rd_mem_addr", 32'(mem_addr), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", 32'(req_ready), 32'h1);
    check("rst_mid_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_write", 32'(wr_count - wr0), 32'd0);
    check("rst_mid_word", mem[5], 32'h12345678);
    check("rst_mid_idle_ready", 32'(req_ready), 32'h1);

    // Back-to-back requests with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 8'h08; req_wdata = '0;
    @(negedge clk);
    lat = 1;
    nrv = 0;
    while (resp_valid !== 1'b1 && lat < 10) begin
      if (req_ready !== 1'b0) nrv++;
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 32'd2);
    check("b2b_first_rdata", resp_rdata, 32'h0000006E);
    check("b2b_ready_low", 32'(nrv), 32'd0);
    check("b2b_resp_ready", 32'(req_ready), 32'h0);
    req_funct3 = 3'b100; req_addr = 8'h3A;
    @(negedge clk);
    check("b2b_idle_ready", 32'(req_ready), 32'h1);
    check("b2b_idle_busy", 32'(busy), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_accepted", 32'(req_ready), 32'h0);
    check("b2b_second_read_idx", 32'(mem_addr), 32'd14);
    @(negedge clk);
    check("b2b_second_valid", 32'(resp_valid), 32'h1);
    check("b2b_second_rdata", resp_rdata, 32'h000000AB);
    check("never_read_and_write", 32'(both_hi), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
